// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressed data memory: FSM states and
// default geometry. Imported by the interface, the byte array and the top.
// Build option DATA_MEMORY_BYTE_EN_EN is consumed by the top only.
package data_memory_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of byte lanes in one word.
  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory.
// master = requester (drives req_*, rsp_ready); slave = memory.
// One outstanding request at a time; response held until rsp_ready.
interface data_memory_if #(
  parameter int DATA_W = data_memory_pkg::DEF_DATA_W,
  parameter int ADDR_W = data_memory_pkg::DEF_ADDR_W
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_memory_bytes.sv
// Big-endian byte array with a single multi-lane port: lane 0 (MSB) is
// byte addr, lane k is byte addr+k. Read is combinational, write on the
// rising edge. Lanes that fall past DEPTH read 0 and are never written.
module data_memory_bytes
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_lanes,   // bit NB-1 selects lane 0 (MSB)
  output logic [DATA_W-1:0]    rd_data
);

  localparam int NB    = lanes_of(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  // Storage is deliberately not reset; the owner clears it byte by byte.
  logic [7:0] mem [DEPTH];

  logic [IDX_W-1:0] lane_idx [NB];
  logic [NB-1:0]    lane_ok;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    // Range test is done at ADDR_W+1 bits so addr+g can never wrap.
    assign lane_ok[g]  = ({1'b0, addr} + (ADDR_W+1)'(g)) < (ADDR_W+1)'(DEPTH);
    assign lane_idx[g] = addr[IDX_W-1:0] + IDX_W'(g);
    assign rd_data[DATA_W-1-8*g -: 8] = lane_ok[g] ? mem[lane_idx[g]] : 8'h00;
  end

  // Byte-lane write; lane i stores wr_data byte i counted from the MSB.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_lanes[NB-1-i] && lane_ok[i]) begin
          mem[lane_idx[i]] <= wr_data[DATA_W-1-8*i -: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory with out-of-range detection; storage
// cleared one byte per cycle after reset. Response 1 cycle after accept,
// held until rsp_ready; req_ready only while idle. DATA_MEMORY_BYTE_EN_EN: honour req_be.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus,
  output logic          init_done
);

  localparam int NB = lanes_of(DATA_W);
  // Highest legal start address; kept one bit wider than the address so the
  // comparison cannot be fooled by wrap-around.
  localparam logic [ADDR_W:0]   LAST_START = (ADDR_W+1)'(DEPTH - NB);
  localparam logic [ADDR_W-1:0] LAST_BYTE  = ADDR_W'(DEPTH - 1);
  localparam logic [NB-1:0]     MSB_LANE   = NB'(1) << (NB - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              legal;
  logic [NB-1:0]     be_lanes;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_lanes;
  logic [DATA_W-1:0] mem_rdata;

  assign legal = ({1'b0, bus.req_addr} <= LAST_START);

`ifdef DATA_MEMORY_BYTE_EN_EN
  assign be_lanes = bus.req_be;
`else
  // Full-word writes; byte enables are accepted on the bus but have no effect.
  logic unused_be;
  assign unused_be = ^bus.req_be;
  assign be_lanes  = '1;
`endif

  data_memory_bytes #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bytes (
    .clk      (clk),
    .wr_en    (mem_en),
    .addr     (mem_addr),
    .wr_data  (mem_wdata),
    .wr_lanes (mem_lanes),
    .rd_data  (mem_rdata)
  );

  // Next state, response capture and memory port steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_en      = 1'b0;
    mem_addr    = bus.req_addr;
    mem_wdata   = bus.req_wdata;
    mem_lanes   = be_lanes;

    unique case (state_q)
      INIT: begin
        // Clear uses lane 0 only, so exactly one byte is zeroed per cycle.
        mem_en    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_lanes = MSB_LANE;
        if (cnt_q == LAST_BYTE) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          state_d = RESP;
          err_d   = !legal;
          mem_en  = bus.req_we && legal;
          // Reads capture the array before any write; writes/errors return 0.
          rdata_d = (!bus.req_we && legal) ? mem_rdata : '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (DATA_W=16, DEPTH=64): byte-array
// reference model, per-cycle compare of the handshake and response outputs,
// directed corner cases plus randomized traffic and resets.
module tb_data_memory;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 16;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;

  data_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_memory #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit          chk_en    = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [15:0] exp_rdata = '0;

  logic [7:0] model_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte array, big-endian word assembly.
  function automatic bit m_legal(input int addr);
    return (addr + NB - 1) <= (DEPTH - 1);
  endfunction

  function automatic logic [15:0] m_read(input int addr);
    logic [15:0] r = '0;
    if (m_legal(addr))
      for (int i = 0; i < NB; i++) r = (r << 8) | 16'(model_mem[addr + i]);
    return r;
  endfunction

  task automatic m_write(input int addr, input logic [15:0] wdata, input logic [1:0] be);
    logic [1:0] lanes;
`ifdef DATA_MEMORY_BYTE_EN_EN
    lanes = be;
`else
    lanes = 2'b11;
`endif
    if (m_legal(addr))
      for (int i = 0; i < NB; i++)
        if (lanes[NB-1-i]) model_mem[addr + i] = wdata[8*(NB-1-i) +: 8];
  endtask

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      chk("init_done", 32'(init_done), 32'(exp_done));
      if (exp_valid) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
    end
  end

  // Release reset (at a negedge) and step n clear cycles.
  task automatic run_init(input int n);
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    rst_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      exp_done  = (k >= DEPTH);
      exp_ready = (k >= DEPTH);
      exp_valid = 1'b0;
      @(negedge clk);
      if (k == DEPTH - 1) chk("init_done_at_63", 32'(init_done), 32'd0);
      if (k == DEPTH)     chk("init_done_at_64", 32'(init_done), 32'd1);
    end
  endtask

  // Assert reset between edges and check the outputs drop at once.
  task automatic assert_reset(input string tag);
    #2;
    rst_n     = 1'b0;
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
    #1;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    chk({tag, "_init_done"}, 32'(init_done),     32'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One transaction, starting and ending on a negedge with the DUT idle.
  task automatic access(input bit we, input int addr, input logic [15:0] wdata,
                        input logic [1:0] be, input int hold,
                        output logic [15:0] dut_rdata, output logic dut_err);
    int w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w != 0) chk("ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = AW'(addr);
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.rsp_ready = 1'b0;
    exp_ready = 1'b0;
    exp_valid = 1'b1;
    exp_err   = !m_legal(addr);
    exp_rdata = (we || !m_legal(addr)) ? 16'h0000 : m_read(addr);
    if (we) m_write(addr, wdata, be);
    @(negedge clk);
    // Scramble request fields to show they are ignored while responding.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = 16'($urandom);
    dut_rdata = bus.rsp_rdata;
    dut_err   = bus.rsp_err;
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    logic [15:0] be_exp;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_init_done", 32'(init_done),     32'd0);
    chk_en = 1'b1;

    run_init(DEPTH);
    for (int a = 0; a <= DEPTH - NB; a++) begin
      access(1'b0, a, 16'h0, 2'b11, 0, rd, er);
      chk("cleared_read", 32'(rd), 32'h0);
    end

    // Big-endian placement and unaligned reads.
    access(1'b1, 5, 16'hA1B2, 2'b11, 0, rd, er);
    chk("wr5_rdata", 32'(rd), 32'h0);
    access(1'b0, 5, 16'h0, 2'b11, 0, rd, er);
    chk("rd5", 32'(rd), 32'hA1B2);
    access(1'b0, 6, 16'h0, 2'b11, 0, rd, er);
    chk("rd6_hi", 32'(rd[15:8]), 32'hB2);
    access(1'b0, 4, 16'h0, 2'b11, 0, rd, er);
    chk("rd4", 32'(rd), 32'h00A1);

    // Range boundary and no-wrap.
    access(1'b1, 63, 16'hDEAD, 2'b11, 0, rd, er);
    chk("wr63_err", 32'(er), 32'd1);
    chk("wr63_rdata", 32'(rd), 32'h0);
    access(1'b0, 63, 16'h0, 2'b11, 0, rd, er);
    chk("rd63_err", 32'(er), 32'd1);
    chk("rd63_rdata", 32'(rd), 32'h0);
    access(1'b0, 62, 16'h0, 2'b11, 0, rd, er);
    chk("rd62_err", 32'(er), 32'd0);
    chk("rd62_unchanged", 32'(rd), 32'h0);
    access(1'b0, 16'hFFFF, 16'h0, 2'b11, 0, rd, er);
    chk("rdFFFF_err", 32'(er), 32'd1);

    // Byte enables (effect depends on build option).
    access(1'b1, 10, 16'hFFFF, 2'b11, 0, rd, er);
    access(1'b1, 10, 16'h1234, 2'b01, 0, rd, er);
    access(1'b0, 10, 16'h0, 2'b11, 0, rd, er);
`ifdef DATA_MEMORY_BYTE_EN_EN
    be_exp = 16'hFF34;
`else
    be_exp = 16'h1234;
`endif
    chk("be_merge", 32'(rd), 32'(be_exp));

    // Backpressure: response held for 5 cycles (checked every cycle).
    access(1'b0, 10, 16'h0, 2'b11, 5, rd, er);
    chk("held_rdata", 32'(bus.rsp_valid), 32'd0);

    // Randomized traffic.
    repeat (400) begin
      int sel;
      int addr;
      sel = $urandom_range(0, 7);
      if (sel == 0)      addr = $urandom_range(60, 70);
      else if (sel == 1) addr = 65535 - $urandom_range(0, 2);
      else               addr = $urandom_range(0, 62);
      access(1'($urandom), addr, 16'($urandom), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), rd, er);
    end

    // Reset in IDLE, then mid-clear at counter 30, then a full clear.
    assert_reset("rst_idle");
    run_init(30);
    assert_reset("rst_init");
    run_init(DEPTH);

    // Dirty the memory, then reset during a pending response.
    access(1'b1, 20, 16'h5A5A, 2'b11, 0, rd, er);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'd20;
    bus.rsp_ready = 1'b0;
    exp_ready = 1'b0;
    exp_valid = 1'b1;
    exp_err   = 1'b0;
    exp_rdata = m_read(20);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("resp_before_rst", 32'(bus.rsp_rdata), 32'h5A5A);
    assert_reset("rst_resp");
    run_init(DEPTH);
    for (int a = 18; a <= 22; a++) begin
      access(1'b0, a, 16'h0, 2'b11, 0, rd, er);
      chk("recleared_read", 32'(rd), 32'h0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 64, storage size in bytes.
REQ-003 Parameter ADDR_W, default 16, byte-address width.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  byte address of the word's most-significant byte.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_be  in  DATA_W/8  byte-write enables; bit DATA_W/8-1 selects the MSB lane.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  access was out of range.
REQ-016 init_done  out  1  storage clear has completed.

Function
REQ-017 Storage SHALL be DEPTH bytes, big-endian: byte addr maps to word bits [DATA_W-1:DATA_W-8], and addr+k maps to the next lower lane.
REQ-018 FSM states SHALL be INIT, IDLE and RESP; reset enters INIT.
REQ-019 INIT SHALL zero one byte per cycle at addresses 0..DEPTH-1, then enter IDLE and set init_done=1, taking exactly DEPTH cycles.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on the cycle req_valid && req_ready; the FSM then enters RESP on the next edge.
REQ-022 Accesses may be unaligned; any addr with addr+DATA_W/8-1 <= DEPTH-1 is legal.
REQ-023 For an illegal address: rsp_err=1, no byte is written, rsp_rdata=0. Address arithmetic SHALL NOT wrap.
REQ-024 Read latency: rsp_valid=1 and rsp_rdata SHALL be valid on the cycle after acceptance.
REQ-025 A write SHALL update the selected bytes on the accept edge; its response follows one cycle later with rsp_rdata=0.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; that edge returns the FSM to IDLE and clears rsp_valid.
REQ-027 A read issued immediately after a write to an overlapping address SHALL return the newly written bytes.
REQ-028 Maximum throughput: one request per two cycles when rsp_ready is held at 1.

Reset
REQ-029 Asserting rst_n low SHALL immediately set req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, reset the clear counter to 0, and set state to INIT.
REQ-030 Reset during INIT SHALL restart the clear from address 0.
REQ-031 Reset during RESP SHALL drop the pending response.
REQ-032 The storage array itself is not asynchronously reset; it is cleared only by INIT.

Configuration
REQ-033 Macro DATA_MEMORY_BYTE_EN_EN: when defined, writes SHALL honour req_be per lane.
REQ-034 When DATA_MEMORY_BYTE_EN_EN is undefined, req_be SHALL be ignored and every write SHALL store all DATA_W/8 bytes.

Structure
REQ-035 Package data_memory_pkg SHALL hold the FSM state typedef (INIT/IDLE/RESP) and the default DATA_W, DEPTH and ADDR_W constants.
REQ-036 Sub-module data_memory_bytes SHALL hold the byte array with one multi-lane read/write port; data_memory holds the FSM, range check and handshake.

Verification (DATA_W=16, DEPTH=64)
REQ-037 Release reset -> init_done rises exactly 64 cycles later; a read of every address 0..62 returns 0x0000.
REQ-038 Write 0xA1B2 at addr 5, then read addr 5 -> 0xA1B2; read addr 6 -> 0xB2 in bits [15:8]; read addr 4 -> 0x00A1.
REQ-039 Write at addr 63 -> rsp_err=1 and memory is unchanged; read at addr 63 -> rsp_err=1, rsp_rdata=0x0000; read at addr 62 -> rsp_err=0.
REQ-040 With the macro defined: write 0xFFFF at addr 10, then write 0x1234 with be=2'b01 -> read returns 0xFF34. With the macro undefined, the same sequence returns 0x1234.
REQ-041 Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; raising rsp_ready -> IDLE on the next edge.
REQ-042 Assert rst_n low mid-INIT (at counter 30) and mid-RESP -> outputs return to reset values immediately; the clear restarts and takes a full 64 cycles.
